// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready stage with a main entry and a one-word skid buffer.
// Upstream ready is registered, so in_ready never depends combinationally on out_ready.
module pipe_skid_stage #(
   parameter int unsigned             BIT_WIDTH   = 32,
   parameter logic [BIT_WIDTH-1:0]    RESET_VALUE = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_WIDTH-1:0] out_data,
   output logic [1:0]           count
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic [1:0]           r_count;
   logic [BIT_WIDTH-1:0] r_main;
   logic [BIT_WIDTH-1:0] r_skid;

   logic w_in_fire;
   logic w_out_fire;
   logic w_load_main;
   logic w_main_from_skid;
   logic w_load_skid;

   assign w_in_fire  = in_valid & r_in_ready;
   assign w_out_fire = r_out_valid & out_ready;

   always_comb begin
      w_state_nxt      = r_state;
      w_load_main      = 1'b0;
      w_main_from_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (flush) begin
         // flush wins over any concurrent transfer; data registers keep their contents
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  w_load_main = 1'b1;
                  w_state_nxt = ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (w_in_fire && w_out_fire) begin
                  w_load_main = 1'b1;
               end else if (w_in_fire) begin
                  w_load_skid = 1'b1;
                  w_state_nxt = ST_FULL;
               end else if (w_out_fire) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_out_fire) begin
                  w_load_main      = 1'b1;
                  w_main_from_skid = 1'b1;
                  w_state_nxt      = ST_BUSY;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_count     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt != ST_FULL);
         r_out_valid <= (w_state_nxt != ST_EMPTY);
         r_count     <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_main <= RESET_VALUE;
         r_skid <= RESET_VALUE;
      end else begin
         if (w_load_main) begin
            r_main <= w_main_from_skid ? r_skid : in_data;
         end
         if (w_load_skid) begin
            r_skid <= in_data;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_main;
   assign count     = r_count;

endmodule
